// File: rtl/instr_register_alu_if.sv
// Bus between the stimulus driver (master) and the instruction register (slave).
interface instr_register_alu_if #(
    parameter int DEPTH = 32,
    parameter int OP_W  = 32,
    parameter int RES_W = 64
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORD_W = 4 + 2 * OP_W + RES_W;

    logic                    load_en;
    logic [3:0]              opcode;
    logic signed [OP_W-1:0]  operand_a;
    logic signed [OP_W-1:0]  operand_b;
    logic [PTR_W-1:0]        write_pointer;
    logic [PTR_W-1:0]        read_pointer;
    logic [WORD_W-1:0]       instruction_word;
    logic                    word_valid;
    logic [15:0]             wr_count;

    modport master (
        output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  instruction_word, word_valid, wr_count
    );

    modport slave (
        input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output instruction_word, word_valid, wr_count
    );
endinterface

// File: rtl/instr_register_alu.sv
// Instruction register: writes go through one capture stage (S1) whose result is
// computed combinationally and committed one edge later; reads are registered and
// forward the S1 entry so a read never observes a stale value for an in-flight write.
module instr_register_alu #(
    parameter int DEPTH = 32,
    parameter int OP_W  = 32,
    parameter int RES_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_register_alu_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORD_W = 4 + 2 * OP_W + RES_W;

    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0,
        OP_PASSA = 4'd1,
        OP_PASSB = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MULT  = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7
    } opcode_t;

    // Signed result at RES_W; operands are widened first so ADD/SUB/MULT cannot overflow.
    // Division uses if/else rather than ?: so the signed context of the operands is kept.
    function automatic logic [RES_W-1:0] compute_result(
        input logic [3:0]      opc,
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        logic signed [RES_W-1:0] a_x;
        logic signed [RES_W-1:0] b_x;
        logic [RES_W-1:0]        res;
        a_x = {{(RES_W-OP_W){a[OP_W-1]}}, a};
        b_x = {{(RES_W-OP_W){b[OP_W-1]}}, b};
        case (opc)
            OP_ZERO:  res = {RES_W{1'b0}};
            OP_PASSA: res = a_x;
            OP_PASSB: res = b_x;
            OP_ADD:   res = a_x + b_x;
            OP_SUB:   res = a_x - b_x;
            OP_MULT:  res = a_x * b_x;
            OP_DIV: begin
                if (b_x == {RES_W{1'b0}}) res = {RES_W{1'b0}};
                else                      res = a_x / b_x;
            end
            OP_MOD: begin
                if (b_x == {RES_W{1'b0}}) res = {RES_W{1'b0}};
                else                      res = a_x % b_x;
            end
            default:  res = {RES_W{1'b0}};
        endcase
        return res;
    endfunction

    logic                s1_valid_q, s1_valid_d;
    logic [3:0]          s1_opc_q,   s1_opc_d;
    logic [OP_W-1:0]     s1_a_q,     s1_a_d;
    logic [OP_W-1:0]     s1_b_q,     s1_b_d;
    logic [PTR_W-1:0]    s1_ptr_q,   s1_ptr_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [WORD_W-1:0]   instruction_word_q;
    logic                word_valid_q;
    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;

    logic [RES_W-1:0]    s1_result_s;
    logic [WORD_W-1:0]   s1_word_s;
    logic                fwd_hit_s;

    assign s1_result_s = compute_result(s1_opc_q, s1_a_q, s1_b_q);
    assign s1_word_s   = {s1_opc_q, s1_a_q, s1_b_q, s1_result_s};
    assign fwd_hit_s   = s1_valid_q && (s1_ptr_q == bus.read_pointer);

    assign bus.instruction_word = instruction_word_q;
    assign bus.word_valid       = word_valid_q;
    assign bus.wr_count         = wr_count_q;

    // Next state of the capture stage and the saturating write counter
    always_comb begin
        s1_valid_d = bus.load_en;
        if (bus.load_en) begin
            s1_opc_d = bus.opcode;
            s1_a_d   = bus.operand_a;
            s1_b_d   = bus.operand_b;
            s1_ptr_d = bus.write_pointer;
        end else begin
            s1_opc_d = s1_opc_q;
            s1_a_d   = s1_a_q;
            s1_b_d   = s1_b_q;
            s1_ptr_d = s1_ptr_q;
        end
        if (bus.load_en && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Capture stage, write counter and registered read port with S1 forwarding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q         <= 1'b0;
            s1_opc_q           <= 4'd0;
            s1_a_q             <= {OP_W{1'b0}};
            s1_b_q             <= {OP_W{1'b0}};
            s1_ptr_q           <= {PTR_W{1'b0}};
            wr_count_q         <= 16'd0;
            instruction_word_q <= {WORD_W{1'b0}};
            word_valid_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_opc_q   <= s1_opc_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_ptr_q   <= s1_ptr_d;
            wr_count_q <= wr_count_d;
            if (fwd_hit_s) begin
                instruction_word_q <= s1_word_s;
                word_valid_q       <= 1'b1;
            end else begin
                instruction_word_q <= mem_q[bus.read_pointer];
                word_valid_q       <= valid_q[bus.read_pointer];
            end
        end
    end

    // Storage array: commit the S1 entry with its result one edge after capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WORD_W{1'b0}};
            end
            valid_q <= {DEPTH{1'b0}};
        end else if (s1_valid_q) begin
            mem_q[s1_ptr_q]   <= s1_word_s;
            valid_q[s1_ptr_q] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_register_alu.sv
// Bench for instr_register_alu: a reference model plus directed literal checks.
module tb_instr_register_alu;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    instr_register_alu_if bus ();

    instr_register_alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: an entry shows every write captured at an earlier edge.
    logic [131:0] m_word [32];
    logic         m_vld  [32];
    int           m_cnt;
    logic [131:0] exp_word;
    logic         exp_vld;
    logic [15:0]  exp_cnt;

    function automatic logic [63:0] model_res(input int opc, input int a, input int b);
        longint la;
        longint lb;
        la = a;
        lb = b;
        case (opc)
            1:       return la;
            2:       return lb;
            3:       return la + lb;
            4:       return la - lb;
            5:       return la * lb;
            6:       return (lb == 64'sd0) ? 64'sd0 : la / lb;
            7:       return (lb == 64'sd0) ? 64'sd0 : la % lb;
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update at each rising edge, then compare just after it.
    initial begin
        int rp;
        int wp;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    m_word[i] = 132'd0;
                    m_vld[i]  = 1'b0;
                end
                m_cnt    = 0;
                exp_word = 132'd0;
                exp_vld  = 1'b0;
                exp_cnt  = 16'd0;
            end else begin
                rp       = int'(bus.read_pointer);
                exp_word = m_word[rp];
                exp_vld  = m_vld[rp];
                if (bus.load_en) begin
                    wp         = int'(bus.write_pointer);
                    m_word[wp] = {bus.opcode, bus.operand_a, bus.operand_b,
                                  model_res(int'(bus.opcode), int'(bus.operand_a), int'(bus.operand_b))};
                    m_vld[wp]  = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
                exp_cnt = m_cnt[15:0];
            end
            #1;
            check("model_word",  bus.instruction_word, exp_word);
            check("model_valid", {131'd0, bus.word_valid}, {131'd0, exp_vld});
            check("model_count", {116'd0, bus.wr_count}, {116'd0, exp_cnt});
        end
    end

    // One clock edge with the given inputs; returns just after the compare point.
    task automatic step(input logic ld, input logic [3:0] op, input int a, input int b,
                        input int wp, input int rp);
        @(negedge clk);
        bus.load_en       = ld;
        bus.opcode        = op;
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.write_pointer = wp[4:0];
        bus.read_pointer  = rp[4:0];
        @(posedge clk);
        #2;
    endtask

    task automatic check_entry(input string name, input logic [3:0] opc, input int a, input int b,
                               input logic [63:0] res);
        logic [131:0] w;
        w = bus.instruction_word;
        check({name, "_opc"},   {128'd0, w[131:128]}, {128'd0, opc});
        check({name, "_a"},     {100'd0, w[127:96]},  {100'd0, a});
        check({name, "_b"},     {100'd0, w[95:64]},   {100'd0, b});
        check({name, "_res"},   {68'd0, w[63:0]},     {68'd0, res});
        check({name, "_valid"}, {131'd0, bus.word_valid}, 132'd1);
    endtask

    task automatic check_count(input string name, input logic [15:0] cnt);
        check(name, {116'd0, bus.wr_count}, {116'd0, cnt});
    endtask

    initial begin
        bus.load_en       = 1'b0;
        bus.opcode        = 4'd0;
        bus.operand_a     = 32'd0;
        bus.operand_b     = 32'd0;
        bus.write_pointer = 5'd0;
        bus.read_pointer  = 5'd0;

        // Reset mid-sequence with a write in flight, then scan all entries.
        step(1'b0, 4'd0, 0, 0, 0, 0);
        step(1'b0, 4'd0, 0, 0, 0, 0);
        reset = 1'b0;
        step(1'b1, 4'd3, 1, 2, 0, 0);
        step(1'b1, 4'd5, 3, 4, 1, 1);
        reset = 1'b1;
        step(1'b0, 4'd0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 4'd0, 0, 0, 0, i);
            check("scan_word",  bus.instruction_word, 132'd0);
            check("scan_valid", {131'd0, bus.word_valid}, 132'd0);
            check_count("scan_count", 16'd0);
        end

        // ADD -7 + 5 into entry 3.
        step(1'b1, 4'd3, -7, 5, 3, 0);
        step(1'b0, 4'd0, 0, 0, 0, 3);
        step(1'b0, 4'd0, 0, 0, 0, 3);
        check_entry("add", 4'd3, -7, 5, 64'hFFFF_FFFF_FFFF_FFFE);

        // MULT, DIV, MOD and divide-by-zero back to back.
        step(1'b1, 4'd5, 32'h7FFF_FFFF, 2, 4, 0);
        step(1'b1, 4'd6, -9, 2, 5, 0);
        step(1'b1, 4'd7, -9, 4, 6, 0);
        step(1'b1, 4'd6, 123, 0, 7, 0);
        step(1'b0, 4'd0, 0, 0, 0, 4);
        check_entry("mult", 4'd5, 32'h7FFF_FFFF, 2, 64'h0000_0000_FFFF_FFFE);
        step(1'b0, 4'd0, 0, 0, 0, 5);
        check_entry("div", 4'd6, -9, 2, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, 4'd0, 0, 0, 0, 6);
        check_entry("mod", 4'd7, -9, 4, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b0, 4'd0, 0, 0, 0, 7);
        check_entry("div0", 4'd6, 123, 0, 64'd0);
        check_count("count5", 16'd5);

        // Forwarding: read entry 9 across its own write.
        step(1'b1, 4'd2, 0, 11, 9, 9);
        check("fwd_old_word",  bus.instruction_word, 132'd0);
        check("fwd_old_valid", {131'd0, bus.word_valid}, 132'd0);
        step(1'b0, 4'd0, 0, 0, 0, 9);
        check_entry("fwd_s1", 4'd2, 0, 11, 64'd11);
        step(1'b0, 4'd0, 0, 0, 0, 9);
        check_entry("fwd_mem", 4'd2, 0, 11, 64'd11);

        // Back-to-back writes to entry 2: youngest wins.
        step(1'b1, 4'd4, 10, 3, 2, 0);
        step(1'b1, 4'd0, 0, 0, 2, 2);
        check_entry("b2b_first", 4'd4, 10, 3, 64'd7);
        step(1'b0, 4'd0, 0, 0, 0, 2);
        check_entry("b2b_fwd", 4'd0, 0, 0, 64'd0);
        step(1'b0, 4'd0, 0, 0, 0, 2);
        check_entry("b2b_mem", 4'd0, 0, 0, 64'd0);
        check_count("count8", 16'd8);

        // Long write stream: all opcodes, zero and negative divisors, counter saturation.
        for (int i = 0; i < 70000; i++) begin
            if (i % 100 == 0) step(1'b1, 4'(i % 16), 32'h8000_0000, -1, i % 32, (i * 7) % 32);
            else              step(1'b1, 4'(i % 16), i * 1103 - 35000000, (i % 7) - 3, i % 32, (i * 7) % 32);
        end
        check_count("sat", 16'hFFFF);
        step(1'b1, 4'd3, 1, 1, 0, 0);
        check_count("sat_hold", 16'hFFFF);

        // Reset one cycle after a capture discards the in-flight write.
        reset = 1'b1;
        step(1'b0, 4'd0, 0, 0, 0, 0);
        reset = 1'b0;
        step(1'b0, 4'd0, 0, 0, 0, 20);
        check_count("rst_count", 16'd0);
        step(1'b1, 4'd1, 5, 0, 20, 0);
        reset = 1'b1;
        step(1'b0, 4'd0, 0, 0, 0, 20);
        reset = 1'b0;
        step(1'b0, 4'd0, 0, 0, 0, 20);
        check("drop_word",  bus.instruction_word, 132'd0);
        check("drop_valid", {131'd0, bus.word_valid}, 132'd0);
        check_count("drop_count", 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
